// File: rtl/d_cache_arbiter.sv
// ---------------------------------------------------------------------------
// d_cache_arbiter
// Arbiter and sequencer for the single-port, byte-addressed data cache.
// Two requesters share the port: the pipeline MEM stage (cpu_*) and the
// program/data loader (ld_*). After reset the loader owns the cache until it
// pulses ld_done. From then on the CPU has priority, except that a waiting
// loader is forced in after MaxStreak consecutive CPU grants.
//
// Ports
//   clk, rst                 rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata    MEM-stage access, request held until cpu_gnt
//   cpu_gnt                  CPU access performed this cycle
//   cpu_rvalid/cpu_rdata     load data, one cycle after a load grant
//   cpu_err                  one-cycle pulse after an out-of-range CPU grant
//   cpu_stall                cpu_req & ~cpu_gnt, to the hazard unit
//   ld_req/addr/wdata        loader write, request held until ld_gnt
//   ld_done                  one-cycle pulse: boot image fully written
//   ld_gnt                   loader write performed this cycle
//   mem_we/addr/wd           cache write-enable, address, write data
//   mem_rd                   cache read data, valid one cycle after a read
//   boot_busy                high while the loader owns the cache
// ---------------------------------------------------------------------------
module d_cache_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 120,
    parameter int unsigned MaxStreak = 4
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [31:0]          cpu_addr,
    input  logic [DataWidth-1:0] cpu_wdata,
    output logic                 cpu_gnt,
    output logic                 cpu_rvalid,
    output logic [DataWidth-1:0] cpu_rdata,
    output logic                 cpu_err,
    output logic                 cpu_stall,

    input  logic                 ld_req,
    input  logic [31:0]          ld_addr,
    input  logic [DataWidth-1:0] ld_wdata,
    input  logic                 ld_done,
    output logic                 ld_gnt,

    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [DataWidth-1:0] mem_wd,
    input  logic [DataWidth-1:0] mem_rd,

    output logic                 boot_busy
);

    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned SumWidth    = AddrWidth + 1;
    localparam int unsigned StreakWidth = 4;

    localparam logic [SumWidth-1:0]    DepthExt  = SumWidth'(Depth);
    localparam logic [SumWidth-1:0]    WordSpan  = SumWidth'(3);
    localparam logic [StreakWidth-1:0] StreakMax = StreakWidth'(MaxStreak);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [StreakWidth-1:0] streak_q;
    logic [StreakWidth-1:0] streak_d;

    logic                   cpu_gnt_raw;
    logic                   ld_gnt_raw;
    logic                   override;

    logic                   cpu_in_range;
    logic                   ld_in_range;

    logic                   rd_pend_q;
    logic                   rd_ok_q;
    logic                   err_q;

    logic [AddrWidth-1:0]   hold_addr_q;
    logic [DataWidth-1:0]   hold_wd_q;

    // Range check: the last byte of the word must lie inside the cache.
    // The extra sum bit keeps addresses near 2^32 from wrapping into range.
    always_comb begin
        cpu_in_range = ({1'b0, cpu_addr} + WordSpan) < DepthExt;
        ld_in_range  = ({1'b0, ld_addr}  + WordSpan) < DepthExt;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_d     = state_q;
        cpu_gnt_raw = 1'b0;
        ld_gnt_raw  = 1'b0;
        override    = 1'b0;
        boot_busy   = 1'b0;

        case (state_q)
            BOOT: begin
                // Loader owns the port; an out-of-range loader word is not granted here.
                boot_busy  = 1'b1;
                ld_gnt_raw = ld_req & ld_in_range;
                if (ld_done) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                override    = ld_req & (streak_q == StreakMax);
                cpu_gnt_raw = cpu_req & ~override;
                ld_gnt_raw  = ld_req & ~cpu_gnt_raw;
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        // No access is allowed to reach the cache while reset is held.
        cpu_gnt   = cpu_gnt_raw & ~rst;
        ld_gnt    = ld_gnt_raw & ~rst;
        cpu_stall = cpu_req & ~cpu_gnt;
    end

    // Streak of CPU grants taken while the loader was waiting
    always_comb begin
        streak_d = streak_q;
        if (ld_gnt || !ld_req) begin
            streak_d = '0;
        end else if (cpu_gnt && (streak_q != StreakMax)) begin
            streak_d = streak_q + StreakWidth'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Cache port mux; address and data park on the last granted access
    always_comb begin
        mem_addr = hold_addr_q;
        mem_wd   = hold_wd_q;
        mem_we   = 1'b0;
        if (cpu_gnt) begin
            mem_addr = cpu_addr;
            mem_wd   = cpu_wdata;
            mem_we   = cpu_we & cpu_in_range;
        end else if (ld_gnt) begin
            mem_addr = ld_addr;
            mem_wd   = ld_wdata;
            mem_we   = ld_in_range;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr_q <= '0;
            hold_wd_q   <= '0;
        end else begin
            hold_addr_q <= mem_addr;
            hold_wd_q   <= mem_wd;
        end
    end

    // Load return tracking and out-of-range error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_q <= 1'b0;
            rd_ok_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rd_pend_q <= cpu_gnt & ~cpu_we;
            rd_ok_q   <= cpu_gnt & ~cpu_we & cpu_in_range;
            err_q     <= cpu_gnt & ~cpu_in_range;
        end
    end

    // Cache read data is already registered, so it is forwarded directly.
    always_comb begin
        cpu_rvalid = rd_pend_q;
        cpu_err    = err_q;
        cpu_rdata  = rd_ok_q ? mem_rd : '0;
    end

endmodule

// File: tb/tb_d_cache_arbiter.sv
// ---------------------------------------------------------------------------
// tb_d_cache_arbiter
// Bench for d_cache_arbiter: a byte-array cache model on the memory port, a
// transaction-level reference model of the arbitration rules, directed
// sequences for boot/reset/pipelined-load corners, a vector table for the
// starvation and range cases, and a randomized phase.
// ---------------------------------------------------------------------------
module tb_d_cache_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 120;
    localparam int unsigned MAXS  = 4;

    logic          clk;
    logic          rst;
    logic          cpu_req;
    logic          cpu_we;
    logic [31:0]   cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;
    logic          cpu_stall;
    logic          ld_req;
    logic [31:0]   ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_done;
    logic          ld_gnt;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;
    logic          boot_busy;

    int checks;
    int errors;

    d_cache_arbiter #(
        .DataWidth (DW),
        .Depth     (DEPTH),
        .MaxStreak (MAXS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .cpu_stall  (cpu_stall),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_done    (ld_done),
        .ld_gnt     (ld_gnt),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .boot_busy  (boot_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit inr(input logic [31:0] a);
        return (64'(a) + 64'd3) < 64'(DEPTH);
    endfunction

    // Cache model: little-endian byte array, registered read port
    logic [7:0] cache [DEPTH];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) cache[i] = 8'h00;
    end

    function automatic logic [31:0] cache_word(input logic [31:0] a);
        if (!inr(a)) return 32'h0;
        return {cache[int'(a) + 3], cache[int'(a) + 2], cache[int'(a) + 1], cache[int'(a)]};
    endfunction

    always @(posedge clk) begin
        mem_rd <= cache_word(mem_addr);
        if (mem_we && inr(mem_addr)) begin
            for (int b = 0; b < 4; b++) cache[int'(mem_addr) + b] = mem_wd[8*b +: 8];
        end
    end

    // Reference model state
    bit          m_boot;
    int          m_streak;
    logic [31:0] m_hold_addr;
    logic [31:0] m_hold_wd;
    bit          m_err;
    logic [31:0] m_rdq [$];
    logic [7:0]  mm [DEPTH];

    function automatic logic [31:0] mm_word(input logic [31:0] a);
        return {mm[int'(a) + 3], mm[int'(a) + 2], mm[int'(a) + 1], mm[int'(a)]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model for this cycle, then advance the model.
    task automatic model_step();
        bit          eg_cpu;
        bit          eg_ld;
        bit          ew;
        logic [31:0] ea;
        logic [31:0] ewd;
        bit          ervalid;
        logic [31:0] erdata;

        if (rst) begin
            m_boot      = 1'b1;
            m_streak    = 0;
            m_hold_addr = '0;
            m_hold_wd   = '0;
            m_err       = 1'b0;
            m_rdq.delete();
            chk("rst cpu_gnt",    32'(cpu_gnt),    32'h0);
            chk("rst ld_gnt",     32'(ld_gnt),     32'h0);
            chk("rst mem_we",     32'(mem_we),     32'h0);
            chk("rst mem_addr",   mem_addr,        32'h0);
            chk("rst mem_wd",     mem_wd,          32'h0);
            chk("rst cpu_rvalid", 32'(cpu_rvalid), 32'h0);
            chk("rst cpu_rdata",  cpu_rdata,       32'h0);
            chk("rst cpu_err",    32'(cpu_err),    32'h0);
            chk("rst cpu_stall",  32'(cpu_stall),  32'(cpu_req));
            chk("rst boot_busy",  32'(boot_busy),  32'h1);
            return;
        end

        ervalid = (m_rdq.size() > 0);
        erdata  = ervalid ? m_rdq[0] : 32'h0;

        if (m_boot) begin
            eg_cpu = 1'b0;
            eg_ld  = ld_req && inr(ld_addr);
        end else begin
            eg_ld  = ld_req && (!cpu_req || m_streak >= int'(MAXS));
            eg_cpu = cpu_req && !eg_ld;
        end

        ea  = m_hold_addr;
        ewd = m_hold_wd;
        ew  = 1'b0;
        if (eg_cpu) begin
            ea  = cpu_addr;
            ewd = cpu_wdata;
            ew  = cpu_we && inr(cpu_addr);
        end else if (eg_ld) begin
            ea  = ld_addr;
            ewd = ld_wdata;
            ew  = inr(ld_addr);
        end

        chk("cpu_gnt",    32'(cpu_gnt),    32'(eg_cpu));
        chk("ld_gnt",     32'(ld_gnt),     32'(eg_ld));
        chk("mem_we",     32'(mem_we),     32'(ew));
        chk("mem_addr",   mem_addr,        ea);
        chk("mem_wd",     mem_wd,          ewd);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ervalid));
        chk("cpu_rdata",  cpu_rdata,       erdata);
        chk("cpu_err",    32'(cpu_err),    32'(m_err));
        chk("cpu_stall",  32'(cpu_stall),  32'(cpu_req && !eg_cpu));
        chk("boot_busy",  32'(boot_busy),  32'(m_boot));

        if (ew) begin
            for (int b = 0; b < 4; b++) mm[int'(ea) + b] = ewd[8*b +: 8];
        end
        m_rdq.delete();
        if (eg_cpu && !cpu_we) m_rdq.push_back(inr(cpu_addr) ? mm_word(cpu_addr) : 32'h0);
        m_err = eg_cpu && !inr(cpu_addr);
        if (eg_ld || !ld_req) m_streak = 0;
        else if (eg_cpu && m_streak < int'(MAXS)) m_streak++;
        m_hold_addr = ea;
        m_hold_wd   = ewd;
        if (m_boot && ld_done) m_boot = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
        model_step();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k <= 5) return 32'(4 * $urandom_range(0, 29));
        if (k <= 7) return 32'($urandom_range(110, 130));
        if (k == 8) return 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
        return 32'($urandom());
    endfunction

    typedef struct {
        bit          cr;
        bit          cw;
        logic [31:0] ca;
        logic [31:0] cd;
        bit          lr;
        logic [31:0] la;
        logic [31:0] ldat;
        bit          e_cg;
        bit          e_lg;
        bit          e_we;
        bit          e_err;
    } vec_t;

    vec_t tv [$];

    task automatic add_vec(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                           input bit lr, input logic [31:0] la, input logic [31:0] ldat,
                           input bit e_cg, input bit e_lg, input bit e_we, input bit e_err);
        vec_t v;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.lr = lr; v.la = la; v.ldat = ldat;
        v.e_cg = e_cg; v.e_lg = e_lg; v.e_we = e_we; v.e_err = e_err;
        tv.push_back(v);
    endtask

    logic [31:0] b2b_exp [3];

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < int'(DEPTH); i++) mm[i] = 8'h00;
        m_boot = 1'b1; m_streak = 0; m_hold_addr = '0; m_hold_wd = '0; m_err = 1'b0;

        // Starvation pattern C,C,C,C,L,C,C,C,C,L, then the range boundary
        for (int i = 0; i < 10; i++) begin
            bit is_l;
            is_l = (i == 4) || (i == 9);
            add_vec(1'b1, 1'b1, 32'd16, 32'hC0DE_0000 + 32'(i), 1'b1, 32'd20, 32'h5A5A_0000 + 32'(i),
                    !is_l, is_l, 1'b1, 1'b0);
        end
        add_vec(1'b1, 1'b1, 32'd117, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 32'd116, 32'h0BAD_F00D, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 32'd118, 32'd0,         1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_vec(1'b0, 1'b0, 32'd0,   32'd0,         1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        b2b_exp[0] = 32'h1122_3344;
        b2b_exp[1] = 32'hAABB_CCDD;
        b2b_exp[2] = 32'hCAFE_F00D;

        rst = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;

        sample(); chk("reset boot_busy", 32'(boot_busy), 32'h1); advance();
        sample(); advance();
        rst = 1'b0;

        // Boot load, ld_done coinciding with the last write and a CPU request
        ld_req = 1'b1; ld_addr = 32'd0; ld_wdata = 32'h1122_3344;
        sample();
        chk("boot wr0 ld_gnt", 32'(ld_gnt), 32'h1);
        chk("boot wr0 mem_we", 32'(mem_we), 32'h1);
        advance();
        ld_addr = 32'd4; ld_wdata = 32'hAABB_CCDD; ld_done = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4;
        sample();
        chk("boot wr4 ld_gnt",   32'(ld_gnt),    32'h1);
        chk("boot wr4 mem_we",   32'(mem_we),    32'h1);
        chk("done cycle cpu_gnt", 32'(cpu_gnt),  32'h0);
        chk("done cycle stall",  32'(cpu_stall), 32'h1);
        advance();
        ld_req = 1'b0; ld_done = 1'b0;
        sample();
        chk("run ld4 cpu_gnt",   32'(cpu_gnt),   32'h1);
        chk("run boot_busy",     32'(boot_busy), 32'h0);
        chk("run ld4 mem_addr",  mem_addr,       32'd4);
        advance();
        cpu_req = 1'b0;
        sample();
        chk("ld4 rvalid", 32'(cpu_rvalid), 32'h1);
        chk("ld4 rdata",  cpu_rdata,       32'hAABB_CCDD);
        advance();

        // CPU held off for ten boot cycles, first grant one cycle after ld_done
        rst = 1'b1;
        sample(); advance();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd0;
        for (int i = 0; i < 10; i++) begin
            ld_done = (i == 9);
            sample();
            chk("boot hold cpu_gnt", 32'(cpu_gnt),   32'h0);
            chk("boot hold stall",   32'(cpu_stall), 32'h1);
            advance();
        end
        ld_done = 1'b0;
        sample();
        chk("post done cpu_gnt", 32'(cpu_gnt), 32'h1);
        advance();
        cpu_req = 1'b0;
        sample();
        chk("ld0 rdata", cpu_rdata, 32'h1122_3344);
        advance();

        // Back-to-back loads @0, @4, @8
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd8; cpu_wdata = 32'hCAFE_F00D;
        sample(); chk("st8 mem_we", 32'(mem_we), 32'h1); advance();
        cpu_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cpu_req  = (k < 3);
            cpu_addr = 32'(4 * k);
            sample();
            if (k < 3) chk("b2b cpu_gnt", 32'(cpu_gnt), 32'h1);
            if (k > 0) begin
                chk("b2b rvalid", 32'(cpu_rvalid), 32'h1);
                chk("b2b rdata",  cpu_rdata,       b2b_exp[k-1]);
            end else begin
                chk("b2b rvalid idle", 32'(cpu_rvalid), 32'h0);
            end
            advance();
        end
        sample(); chk("b2b rvalid end", 32'(cpu_rvalid), 32'h0); advance();

        // Reset in the cycle after a load grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'd4;
        sample(); chk("pre-rst cpu_gnt", 32'(cpu_gnt), 32'h1); advance();
        rst = 1'b1; cpu_req = 1'b0;
        sample();
        chk("mid-read rst rvalid", 32'(cpu_rvalid), 32'h0);
        chk("mid-read rst rdata",  cpu_rdata,       32'h0);
        chk("mid-read rst boot",   32'(boot_busy),  32'h1);
        advance();
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'd0;
        for (int i = 0; i < 4; i++) begin
            ld_done = (i == 3);
            sample(); chk("post-rst blocked", 32'(cpu_gnt), 32'h0); advance();
        end
        ld_done = 1'b0;
        sample();
        chk("post-rst grant", 32'(cpu_gnt),   32'h1);
        chk("post-rst boot",  32'(boot_busy), 32'h0);
        advance();
        cpu_req = 1'b0;
        sample(); advance();

        // Vector table
        foreach (tv[i]) begin
            cpu_req = tv[i].cr; cpu_we = tv[i].cw; cpu_addr = tv[i].ca; cpu_wdata = tv[i].cd;
            ld_req = tv[i].lr; ld_addr = tv[i].la; ld_wdata = tv[i].ldat;
            sample();
            chk($sformatf("vec%0d cpu_gnt", i), 32'(cpu_gnt), 32'(tv[i].e_cg));
            chk($sformatf("vec%0d ld_gnt",  i), 32'(ld_gnt),  32'(tv[i].e_lg));
            chk($sformatf("vec%0d mem_we",  i), 32'(mem_we),  32'(tv[i].e_we));
            chk($sformatf("vec%0d cpu_err", i), 32'(cpu_err), 32'(tv[i].e_err));
            advance();
        end

        // Randomized phase against the reference model
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cpu_req   = ($urandom_range(0, 2) != 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = rand_addr();
            cpu_wdata = 32'($urandom());
            ld_req    = 1'($urandom_range(0, 1));
            ld_addr   = rand_addr();
            ld_wdata  = 32'($urandom());
            ld_done   = ($urandom_range(0, 39) == 0);
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
